// File: rtl/hive_jmp_resolve.sv
// Jump resolution tail: carries issued instructions to stage 3, decides taken
// jumps against the test result, redirects the PC and squashes the jump shadow.
module hive_jmp_resolve #(
    parameter int PC_W  = 16,
    parameter int OFS_W = 8,
    parameter int SHD   = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             vld_i,
    input  logic             jmp_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic [OFS_W-1:0] ofs_i,
    input  logic             res_i,
    output logic             rdr_o,
    output logic [PC_W-1:0]  pc_o,
    output logic             kill_o,
    output logic [15:0]      tkn_cnt_o
);

    typedef struct packed {
        logic             jmp;
        logic [PC_W-1:0]  pc;
        logic [OFS_W-1:0] ofs;
    } stg_t;

    localparam logic [2:0] SHD_L = 3'(SHD);

    logic [2:0]      vld_q;
    stg_t            s1_q;
    stg_t            s2_q;
    stg_t            s3_q;
    logic [2:0]      shd_q;
    logic [2:0]      shd_d;
    logic            s3_vld;
    logic            shadowed;
    logic            take;
    logic [PC_W-1:0] ofs_sx;
    logic [PC_W-1:0] tgt;

    // Payload registers are left unreset; the valid chain gates them.
    always_ff @(posedge clk_i) begin
        s1_q <= '{jmp: jmp_i, pc: pc_i, ofs: ofs_i};
        s2_q <= s1_q;
        s3_q <= s2_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[1:0], vld_i};
        end
    end

    assign s3_vld   = vld_q[2];
    assign shadowed = (shd_q != 3'd0);
    assign take     = s3_vld & s3_q.jmp & res_i & ~shadowed;
    assign ofs_sx   = PC_W'($signed(s3_q.ofs));
    assign tgt      = s3_q.pc + PC_W'(1) + ofs_sx;

    always_comb begin
        shd_d = shd_q;
        unique case (1'b1)
            take:     shd_d = SHD_L;
            shadowed: shd_d = shd_q - 3'd1;
            default:  shd_d = shd_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shd_q     <= '0;
            rdr_o     <= 1'b0;
            kill_o    <= 1'b0;
            pc_o      <= '0;
            tkn_cnt_o <= '0;
        end else begin
            shd_q     <= shd_d;
            rdr_o     <= take;
            kill_o    <= s3_vld & shadowed;
            tkn_cnt_o <= tkn_cnt_o + 16'(take);
            if (take) begin
                pc_o <= tgt;
            end
        end
    end

endmodule

// File: tb/tb_hive_jmp_resolve.sv
// Bench for hive_jmp_resolve: a cycle model feeds a scoreboard queue,
// and each scenario task pops and compares every cycle's outputs.
module tb_hive_jmp_resolve;

    localparam int SHD = 3;

    typedef struct packed {
        logic        rst;
        logic        vld;
        logic        jmp;
        logic [15:0] pc;
        logic [7:0]  ofs;
        logic        res;
    } ent_t;

    typedef struct packed {
        logic        rdr;
        logic        kill;
        logic [15:0] pc;
        logic [15:0] cnt;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        vld_i = 1'b0;
    logic        jmp_i = 1'b0;
    logic [15:0] pc_i  = '0;
    logic [7:0]  ofs_i = '0;
    logic        res_i = 1'b0;
    logic        rdr_o;
    logic [15:0] pc_o;
    logic        kill_o;
    logic [15:0] tkn_cnt_o;

    int   checks = 0;
    int   errors = 0;
    int   m_cyc = 0;
    int   last_take = -100;
    exp_t m_exp = '0;
    exp_t sb[$];
    ent_t pipe[$];

    hive_jmp_resolve #(
        .PC_W (16),
        .OFS_W(8),
        .SHD  (SHD)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .vld_i    (vld_i),
        .jmp_i    (jmp_i),
        .pc_i     (pc_i),
        .ofs_i    (ofs_i),
        .res_i    (res_i),
        .rdr_o    (rdr_o),
        .pc_o     (pc_o),
        .kill_o   (kill_o),
        .tkn_cnt_o(tkn_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic ent_t mk(input logic r, input logic v, input logic j,
                                input logic [15:0] p, input logic [7:0] o,
                                input logic rs);
        ent_t e;
        e.rst = r;
        e.vld = v;
        e.jmp = j;
        e.pc  = p;
        e.ofs = o;
        e.res = rs;
        return e;
    endfunction

    function automatic ent_t bub();
        return mk(1'b0, 1'b0, 1'($urandom), 16'($urandom), 8'($urandom),
                  1'($urandom));
    endfunction

    task automatic clear_pipe();
        ent_t z;
        z = '0;
        pipe.delete();
        repeat (3) pipe.push_back(z);
    endtask

    // One cycle: drive the issue slot, present res_i for the entry three
    // cycles old, and push what the outputs must read after the edge.
    task automatic step(input ent_t e);
        ent_t        s3;
        exp_t        x;
        logic        shadowed;
        logic        take;
        logic [15:0] tgt;
        s3 = pipe.pop_front();
        pipe.push_back(e);
        rst_i = e.rst;
        vld_i = e.vld;
        jmp_i = e.jmp;
        pc_i  = e.pc;
        ofs_i = e.ofs;
        res_i = s3.vld ? s3.res : 1'($urandom);
        shadowed = (m_cyc - last_take >= 1) && (m_cyc - last_take <= SHD);
        take = s3.vld && s3.jmp && s3.res && !shadowed;
        tgt = s3.pc + 16'd1 + {{8{s3.ofs[7]}}, s3.ofs};
        x = m_exp;
        x.rdr = take;
        x.kill = s3.vld && shadowed;
        if (take) begin
            x.pc = tgt;
            x.cnt = m_exp.cnt + 16'd1;
            last_take = m_cyc;
        end
        if (e.rst) begin
            clear_pipe();
            x = '0;
            last_take = -100;
        end
        m_exp = x;
        sb.push_back(x);
        m_cyc++;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        exp_t x;
        logic [33:0] got;
        for (int i = 0; i < 2; i++) begin
            step(mk(1'b1, 1'b1, 1'b1, 16'h1234, 8'h7f, 1'b1));
            x = sb.pop_front();
            got = {rdr_o, kill_o, pc_o, tkn_cnt_o};
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL reset_sb[%0d] got=%h exp=%h", i, got, x);
            end
        end
        checks++;
        if (got !== 34'h0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=0", got);
        end
    endtask

    task automatic test_taken();
        ent_t stim[$];
        exp_t x;
        logic [33:0] got;
        int n_rdr = 0;
        int at = -1;
        logic [15:0] tgt = '0;
        logic [15:0] c0;
        c0 = m_exp.cnt;
        stim.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0010, 8'h05, 1'b1));
        repeat (7) stim.push_back(bub());
        foreach (stim[i]) begin
            step(stim[i]);
            x = sb.pop_front();
            got = {rdr_o, kill_o, pc_o, tkn_cnt_o};
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL taken_sb[%0d] got=%h exp=%h", i, got, x);
            end
            if (rdr_o === 1'b1) begin
                n_rdr++;
                at = i;
                tgt = pc_o;
            end
        end
        checks++;
        if (n_rdr != 1 || at != 3 || tgt !== 16'h0016) begin
            errors++;
            $display("FAIL taken_rdr got n=%0d at=%0d pc=%h exp n=1 at=3 pc=0016",
                     n_rdr, at, tgt);
        end
        checks++;
        if (tkn_cnt_o !== c0 + 16'd1) begin
            errors++;
            $display("FAIL taken_cnt got=%h exp=%h", tkn_cnt_o, c0 + 16'd1);
        end
    endtask

    task automatic test_wrap();
        ent_t stim[$];
        exp_t x;
        logic [33:0] got;
        logic [15:0] tg[$];
        stim.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0000, 8'h80, 1'b1));
        repeat (5) stim.push_back(bub());
        stim.push_back(mk(1'b0, 1'b1, 1'b1, 16'hffff, 8'h00, 1'b1));
        repeat (6) stim.push_back(bub());
        foreach (stim[i]) begin
            step(stim[i]);
            x = sb.pop_front();
            got = {rdr_o, kill_o, pc_o, tkn_cnt_o};
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL wrap_sb[%0d] got=%h exp=%h", i, got, x);
            end
            if (rdr_o === 1'b1) tg.push_back(pc_o);
        end
        checks++;
        if (tg.size() != 2) begin
            errors++;
            $display("FAIL wrap_cnt got=%0d redirects exp=2", tg.size());
        end else begin
            checks++;
            if (tg[0] !== 16'hff81 || tg[1] !== 16'h0000) begin
                errors++;
                $display("FAIL wrap_tgt got=%h,%h exp=ff81,0000", tg[0], tg[1]);
            end
        end
    endtask

    task automatic test_not_taken();
        ent_t stim[$];
        exp_t x;
        logic [33:0] got;
        int n_rdr = 0;
        int n_kill = 0;
        stim.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0100, 8'h10, 1'b0));
        stim.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0101, 8'h33, 1'b1));
        stim.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0102, 8'h44, 1'b0));
        repeat (5) stim.push_back(bub());
        foreach (stim[i]) begin
            step(stim[i]);
            x = sb.pop_front();
            got = {rdr_o, kill_o, pc_o, tkn_cnt_o};
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL not_taken_sb[%0d] got=%h exp=%h", i, got, x);
            end
            if (rdr_o === 1'b1) n_rdr++;
            if (kill_o === 1'b1) n_kill++;
        end
        checks++;
        if (n_rdr != 0 || n_kill != 0) begin
            errors++;
            $display("FAIL not_taken got rdr=%0d kill=%0d exp 0 0", n_rdr, n_kill);
        end
    endtask

    task automatic test_shadow();
        ent_t stim[$];
        exp_t x;
        logic [33:0] got;
        logic [15:0] km = '0;
        stim.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0200, 8'hf0, 1'b1));
        for (int k = 0; k < 4; k++)
            stim.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0201 + 16'(k), 8'h01, 1'b1));
        repeat (6) stim.push_back(bub());
        foreach (stim[i]) begin
            step(stim[i]);
            x = sb.pop_front();
            got = {rdr_o, kill_o, pc_o, tkn_cnt_o};
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL shadow_sb[%0d] got=%h exp=%h", i, got, x);
            end
            if (kill_o === 1'b1) km[i] = 1'b1;
        end
        checks++;
        if (km !== 16'h0070) begin
            errors++;
            $display("FAIL shadow_kill got=%h exp=0070", km);
        end
    endtask

    task automatic test_back_to_back();
        ent_t stim[$];
        exp_t x;
        logic [33:0] got;
        logic [15:0] km = '0;
        int n_rdr = 0;
        int at = -1;
        logic [15:0] tgt = '0;
        logic [15:0] c0;
        c0 = m_exp.cnt;
        stim.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0300, 8'h04, 1'b1));
        stim.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0400, 8'h08, 1'b1));
        repeat (6) stim.push_back(bub());
        foreach (stim[i]) begin
            step(stim[i]);
            x = sb.pop_front();
            got = {rdr_o, kill_o, pc_o, tkn_cnt_o};
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL b2b_sb[%0d] got=%h exp=%h", i, got, x);
            end
            if (rdr_o === 1'b1) begin
                n_rdr++;
                at = i;
                tgt = pc_o;
            end
            if (kill_o === 1'b1) km[i] = 1'b1;
        end
        checks++;
        if (n_rdr != 1 || at != 3 || tgt !== 16'h0305 || km !== 16'h0010) begin
            errors++;
            $display("FAIL b2b got n=%0d at=%0d pc=%h kill=%h exp n=1 at=3 pc=0305 kill=0010",
                     n_rdr, at, tgt, km);
        end
        checks++;
        if (tkn_cnt_o !== c0 + 16'd1) begin
            errors++;
            $display("FAIL b2b_cnt got=%h exp=%h", tkn_cnt_o, c0 + 16'd1);
        end
    endtask

    task automatic test_bubbles();
        ent_t stim[$];
        exp_t x;
        logic [33:0] got;
        logic [15:0] km = '0;
        stim.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0500, 8'h02, 1'b1));
        stim.push_back(bub());
        stim.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0502, 8'h00, 1'b1));
        repeat (6) stim.push_back(bub());
        foreach (stim[i]) begin
            step(stim[i]);
            x = sb.pop_front();
            got = {rdr_o, kill_o, pc_o, tkn_cnt_o};
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL bubbles_sb[%0d] got=%h exp=%h", i, got, x);
            end
            if (kill_o === 1'b1) km[i] = 1'b1;
        end
        checks++;
        if (km !== 16'h0020) begin
            errors++;
            $display("FAIL bubbles_kill got=%h exp=0020", km);
        end
    endtask

    task automatic test_reset_mid();
        ent_t stim[$];
        exp_t x;
        logic [33:0] got;
        logic [15:0] km = '0;
        int n_rdr = 0;
        int at = -1;
        stim.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0600, 8'h01, 1'b1));
        repeat (3) stim.push_back(bub());
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0));
        stim.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0700, 8'h00, 1'b1));
        repeat (5) stim.push_back(bub());
        foreach (stim[i]) begin
            step(stim[i]);
            x = sb.pop_front();
            got = {rdr_o, kill_o, pc_o, tkn_cnt_o};
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL rst_mid_sb[%0d] got=%h exp=%h", i, got, x);
            end
            if (rdr_o === 1'b1) begin
                n_rdr++;
                at = i;
            end
            if (kill_o === 1'b1) km[i] = 1'b1;
        end
        checks++;
        if (n_rdr != 1 || at != 3 || km !== 16'h0000 || tkn_cnt_o !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid got n=%0d at=%0d kill=%h cnt=%h exp n=1 at=3 kill=0 cnt=0",
                     n_rdr, at, km, tkn_cnt_o);
        end
    endtask

    task automatic test_random();
        exp_t x;
        logic [33:0] got;
        ent_t e;
        for (int i = 0; i < 400; i++) begin
            e = mk(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7),
                   1'($urandom), 16'($urandom), 8'($urandom), 1'($urandom));
            step(e);
            x = sb.pop_front();
            got = {rdr_o, kill_o, pc_o, tkn_cnt_o};
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL random_sb[%0d] got=%h exp=%h", i, got, x);
            end
        end
    endtask

    initial begin
        clear_pipe();
        @(negedge clk_i);
        test_reset();
        test_taken();
        test_wrap();
        test_not_taken();
        test_shadow();
        test_back_to_back();
        test_bubbles();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
